// File: rtl/dma_pkg.sv
// Shared encodings and widths for the two-channel DMA sequencer.
package dma_pkg;

  localparam int unsigned AW = 8;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_GRANT   = 3'd2;
  localparam logic [2:0] ST_XFER    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Channel identifiers
  localparam logic CH_IO1 = 1'b0;
  localparam logic CH_IO2 = 1'b1;

  // Transfer direction
  localparam logic DIR_IO2MEM = 1'b1;
  localparam logic DIR_MEM2IO = 1'b0;

  // Per-channel programming payload
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [AW-1:0] count;
    logic          dir;
  } chan_cfg_t;

endpackage

// File: rtl/dma_channel_regs.sv
// Address/count/direction registers for one DMA channel.
module dma_channel_regs
  import dma_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  chan_cfg_t cfg_i,
  input  logic      step_i,
  output chan_cfg_t regs_o,
  output logic      armed_o
);

  chan_cfg_t regs_q;

  // Load from config, or advance one word per transfer step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else if (load_i) begin
      regs_q <= cfg_i;
    end else if (step_i) begin
      regs_q.addr  <= regs_q.addr + AW'(1);
      regs_q.count <= regs_q.count - AW'(1);
    end
  end

  assign regs_o  = regs_q;
  assign armed_o = (regs_q.count != '0);

endmodule

// File: rtl/dma_channel_sequencer.sv
// Two-channel round-robin DMA sequencer with bus hold handshake.
module dma_channel_sequencer
  import dma_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          DREQ1,
  input  logic          DREQ2,
  input  logic          HACK,
  input  logic          cfg_we,
  input  logic          cfg_ch,
  input  logic [AW-1:0] cfg_addr,
  input  logic [AW-1:0] cfg_count,
  input  logic          cfg_dir,
  output logic          HREQ,
  output logic          DACK1,
  output logic          DACK2,
  output logic [AW-1:0] AB,
  output logic          Enable_memory,
  output logic          Enable_IO1,
  output logic          Enable_IO2,
  output logic          read_memory,
  output logic          read_io,
  output logic [AW-1:0] word_count,
  output logic          tc,
  output logic          busy
);

  logic [2:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          load1, load2, step1, step2;
  logic          cfg_block, req1, req2, cur_dreq, xfer_now;
  logic [AW-1:0] cnt_left, nx_addr, nx_count;
  chan_cfg_t     cfg_in, ch1, ch2, cur, nxt;
  logic          armed1, armed2;

  logic          hreq_q, hreq_d, dack1_q, dack1_d, dack2_q, dack2_d;
  logic          en_mem_q, en_mem_d, en_io1_q, en_io1_d, en_io2_q, en_io2_d;
  logic          rd_mem_q, rd_mem_d, rd_io_q, rd_io_d, tc_q, tc_d, busy_q, busy_d;
  logic [AW-1:0] ab_q, ab_d, wc_q, wc_d;

  assign cfg_in = {cfg_addr, cfg_count, cfg_dir};

  dma_channel_regs u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load1),
    .cfg_i   (cfg_in),
    .step_i  (step1),
    .regs_o  (ch1),
    .armed_o (armed1)
  );

  dma_channel_regs u_ch2 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load2),
    .cfg_i   (cfg_in),
    .step_i  (step2),
    .regs_o  (ch2),
    .armed_o (armed2)
  );

  // Next state, arbitration, channel control and next output values
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    step1     = 1'b0;
    step2     = 1'b0;
    tc_d      = 1'b0;
    cfg_block = cfg_we && (state_q != ST_IDLE) && (cfg_ch == grant_q);
    load1     = cfg_we && (cfg_ch == CH_IO1) && !cfg_block;
    load2     = cfg_we && (cfg_ch == CH_IO2) && !cfg_block;
    req1      = DREQ1 && armed1;
    req2      = DREQ2 && armed2;
    cur       = (grant_q == CH_IO2) ? ch2 : ch1;
    cur_dreq  = (grant_q == CH_IO2) ? DREQ2 : DREQ1;
    cnt_left  = cur.count - AW'(1);
    xfer_now  = (state_q == ST_XFER);

    case (state_q)
      ST_IDLE: begin
        // A config write racing a request on the same channel lands first
        if (!(cfg_we && ((cfg_ch == CH_IO1 && DREQ1) || (cfg_ch == CH_IO2 && DREQ2))) &&
            (req1 || req2)) begin
          state_d = ST_REQ;
          if (req1 && req2) grant_d = (last_q == CH_IO2) ? CH_IO1 : CH_IO2;
          else              grant_d = req2 ? CH_IO2 : CH_IO1;
        end
      end
      ST_REQ: begin
        if (HACK) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        state_d = HACK ? ST_XFER : ST_RELEASE;
      end
      ST_XFER: begin
        if (grant_q == CH_IO2) step2 = 1'b1;
        else                   step1 = 1'b1;
        if (cnt_left == '0) begin
          state_d = ST_RELEASE;
          tc_d    = 1'b1;
        end else if (!(cur_dreq && HACK)) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!HACK) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs reflect the state and channel values after this edge
    nxt      = (grant_d == CH_IO2) ? ch2 : ch1;
    nx_addr  = nxt.addr + AW'(xfer_now);
    nx_count = nxt.count - AW'(xfer_now);
    hreq_d   = (state_d == ST_REQ) || (state_d == ST_GRANT) || (state_d == ST_XFER);
    dack1_d  = ((state_d == ST_GRANT) || (state_d == ST_XFER)) && (grant_d == CH_IO1);
    dack2_d  = ((state_d == ST_GRANT) || (state_d == ST_XFER)) && (grant_d == CH_IO2);
    en_mem_d = (state_d == ST_XFER);
    en_io1_d = (state_d == ST_XFER) && (grant_d == CH_IO1);
    en_io2_d = (state_d == ST_XFER) && (grant_d == CH_IO2);
    rd_io_d  = (state_d == ST_XFER) && (nxt.dir == DIR_IO2MEM);
    rd_mem_d = (state_d == ST_XFER) && (nxt.dir == DIR_MEM2IO);
    ab_d     = (state_d == ST_XFER) ? nx_addr : '0;
    wc_d     = (state_d != ST_IDLE) ? nx_count : '0;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= CH_IO1;
      last_q   <= CH_IO2;
      hreq_q   <= 1'b0;
      dack1_q  <= 1'b0;
      dack2_q  <= 1'b0;
      en_mem_q <= 1'b0;
      en_io1_q <= 1'b0;
      en_io2_q <= 1'b0;
      rd_mem_q <= 1'b0;
      rd_io_q  <= 1'b0;
      ab_q     <= '0;
      wc_q     <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      hreq_q   <= hreq_d;
      dack1_q  <= dack1_d;
      dack2_q  <= dack2_d;
      en_mem_q <= en_mem_d;
      en_io1_q <= en_io1_d;
      en_io2_q <= en_io2_d;
      rd_mem_q <= rd_mem_d;
      rd_io_q  <= rd_io_d;
      ab_q     <= ab_d;
      wc_q     <= wc_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign HREQ          = hreq_q;
  assign DACK1         = dack1_q;
  assign DACK2         = dack2_q;
  assign AB            = ab_q;
  assign Enable_memory = en_mem_q;
  assign Enable_IO1    = en_io1_q;
  assign Enable_IO2    = en_io2_q;
  assign read_memory   = rd_mem_q;
  assign read_io       = rd_io_q;
  assign word_count    = wc_q;
  assign tc            = tc_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Directed self-checking bench for dma_channel_sequencer.
module tb_dma_channel_sequencer;

  logic       clk, rst;
  logic       DREQ1, DREQ2, HACK, cfg_we, cfg_ch, cfg_dir;
  logic [7:0] cfg_addr, cfg_count;
  logic       HREQ, DACK1, DACK2, Enable_memory, Enable_IO1, Enable_IO2;
  logic       read_memory, read_io, tc, busy;
  logic [7:0] AB, word_count;

  int n_tests = 0;
  int n_fail  = 0;

  dma_channel_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .DREQ1         (DREQ1),
    .DREQ2         (DREQ2),
    .HACK          (HACK),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_addr      (cfg_addr),
    .cfg_count     (cfg_count),
    .cfg_dir       (cfg_dir),
    .HREQ          (HREQ),
    .DACK1         (DACK1),
    .DACK2         (DACK2),
    .AB            (AB),
    .Enable_memory (Enable_memory),
    .Enable_IO1    (Enable_IO1),
    .Enable_IO2    (Enable_IO2),
    .read_memory   (read_memory),
    .read_io       (read_io),
    .word_count    (word_count),
    .tc            (tc),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    DREQ1 = 0; DREQ2 = 0; HACK = 0; cfg_we = 0; cfg_ch = 0;
    cfg_addr = 0; cfg_count = 0; cfg_dir = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic load(input logic ch, input logic [7:0] a, input logic [7:0] c, input logic d);
    cfg_we = 1; cfg_ch = ch; cfg_addr = a; cfg_count = c; cfg_dir = d;
    tick();
    cfg_we = 0;
  endtask

  // Wait (bounded) for the first transfer cycle
  task automatic wait_xfer(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (Enable_memory) seen = 1;
    end
    check({tag, "_xfer_seen"}, 32'(seen), 1);
  endtask

  // Run one grant, then drop HACK in GRANT so no word moves
  task automatic serve(input string tag, output logic [1:0] dk, output logic [7:0] wc);
    bit seen;
    seen = 0;
    HACK = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (DACK1 || DACK2) seen = 1;
    end
    check({tag, "_grant_seen"}, 32'(seen), 1);
    dk = {DACK2, DACK1};
    wc = word_count;
    HACK = 0;
    tick();
    check({tag, "_release_dack"}, {30'd0, DACK2, DACK1}, 0);
    tick();
  endtask

  logic [1:0] dk;
  logic [7:0] wc;
  logic [7:0] exp_ab [4];

  initial begin
    do_reset();
    check("reset_ctrl", {HREQ, DACK1, DACK2, Enable_memory, Enable_IO1, Enable_IO2,
                         read_memory, read_io, tc, busy}, 0);
    check("reset_ab", AB, 0);
    check("reset_wc", word_count, 0);

    // Three-word IO1 transfer, IO to memory
    load(1'b0, 8'd150, 8'd3, 1'b1);
    DREQ1 = 1;
    tick();
    check("t1_req_hreq", {HREQ, busy, DACK1}, 3'b110);
    check("t1_req_wc", word_count, 3);
    HACK = 1;
    tick();
    check("t1_grant", {DACK1, DACK2, Enable_memory, read_io, read_memory}, 5'b10000);
    check("t1_grant_ab", AB, 0);
    tick();
    check("t1_x0_ab", AB, 150);
    check("t1_x0_strb", {Enable_memory, Enable_IO1, Enable_IO2, read_io, read_memory, DACK1}, 6'b110101);
    check("t1_x0_wc", word_count, 3);
    tick();
    check("t1_x1_ab", AB, 151);
    check("t1_x1_wc", word_count, 2);
    tick();
    check("t1_x2_ab", AB, 152);
    check("t1_x2_tc", tc, 0);
    tick();
    check("t1_rel", {tc, HREQ, DACK1, Enable_memory, busy}, 5'b10001);
    check("t1_rel_wc", word_count, 0);
    HACK = 0;
    tick();
    check("t1_idle", {tc, busy}, 0);
    tick(); tick();
    check("t1_unarmed_ignored", {HREQ, busy}, 0);
    DREQ1 = 0;

    // Round robin on ties; HACK drop in GRANT moves no word
    do_reset();
    load(1'b0, 8'd10, 8'd3, 1'b1);
    load(1'b1, 8'd20, 8'd2, 1'b0);
    DREQ1 = 1; DREQ2 = 1;
    serve("rr1", dk, wc);
    check("rr1_dack", dk, 2'b01);
    check("rr1_wc", wc, 3);
    serve("rr2", dk, wc);
    check("rr2_dack", dk, 2'b10);
    check("rr2_wc", wc, 2);
    serve("rr3", dk, wc);
    check("rr3_dack", dk, 2'b01);
    check("rr3_wc", wc, 3);

    // IO2 address wrap, memory to IO
    do_reset();
    exp_ab[0] = 8'hFE; exp_ab[1] = 8'hFF; exp_ab[2] = 8'h00; exp_ab[3] = 8'h01;
    load(1'b1, 8'hFE, 8'd4, 1'b0);
    DREQ2 = 1; HACK = 1;
    wait_xfer("wrap");
    check("wrap_strb", {Enable_IO2, Enable_IO1, read_memory, read_io, DACK2}, 5'b10101);
    check("wrap_ab0", AB, exp_ab[0]);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("wrap_ab%0d", i), AB, exp_ab[i]);
    end
    tick();
    check("wrap_tc", {tc, HREQ, DACK2}, 3'b100);
    HACK = 0; DREQ2 = 0;
    tick();

    // DREQ drop mid-block, then resume
    do_reset();
    load(1'b0, 8'd40, 8'd5, 1'b1);
    DREQ1 = 1; HACK = 1;
    wait_xfer("pause");
    check("pause_ab0", AB, 40);
    tick();
    check("pause_ab1", AB, 41);
    DREQ1 = 0;
    tick();
    check("pause_rel", {Enable_memory, HREQ, tc, busy}, 4'b0001);
    check("pause_rel_wc", word_count, 3);
    HACK = 0;
    tick();
    check("pause_idle", {busy, HREQ}, 0);
    HACK = 1; DREQ1 = 1;
    wait_xfer("resume");
    check("resume_ab", AB, 42);
    check("resume_wc", word_count, 3);

    // Reset during the second transfer word
    do_reset();
    load(1'b0, 8'd100, 8'd4, 1'b1);
    DREQ1 = 1; HACK = 1;
    wait_xfer("rst");
    tick();
    check("rst_x1_ab", AB, 101);
    rst = 1;
    #1;
    check("rst_async_ctrl", {HREQ, DACK1, DACK2, Enable_memory, Enable_IO1, Enable_IO2,
                             read_memory, read_io, tc, busy}, 0);
    check("rst_async_ab", AB, 0);
    check("rst_async_wc", word_count, 0);
    tick();
    rst = 0;
    tick(); tick(); tick(); tick();
    check("rst_dreq_ignored", {HREQ, busy, Enable_memory}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_channel_sequencer.md
DMA_CHANNEL_SEQUENCER -- requirements
Module: dma_channel_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have ports DREQ1 and DREQ2, input, 1 bit each: IO1 and IO2 transfer requests, level-sensitive.
REQ-004 SHALL have port HACK, input, 1 bit: processor grants the bus.
REQ-005 SHALL have port cfg_we, input, 1 bit: one-cycle config load strobe.
REQ-006 SHALL have ports cfg_ch (input, 1 bit; 0 = IO1, 1 = IO2), cfg_addr (input, 8 bits; memory start address), cfg_count (input, 8 bits; word count) and cfg_dir (input, 1 bit; 1 = IO to memory, 0 = memory to IO).
REQ-007 SHALL have port HREQ, output, 1 bit: bus hold request to the processor.
REQ-008 SHALL have ports DACK1 and DACK2, output, 1 bit each: channel acknowledges.
REQ-009 SHALL have port AB, output, 8 bits: memory address.
REQ-010 SHALL have ports Enable_memory, Enable_IO1 and Enable_IO2, output, 1 bit each: device selects.
REQ-011 SHALL have ports read_memory and read_io, output, 1 bit each: read strobes.
REQ-012 SHALL have port word_count, output, 8 bits: remaining count of the granted channel, or 0 when idle.
REQ-013 SHALL have ports tc (output, 1 bit; terminal-count pulse) and busy (output, 1 bit; high when not IDLE).

Function
REQ-014 SHALL keep per-channel registers: addr[7:0], count[7:0], dir; a channel is armed iff count != 0.
REQ-015 cfg_we SHALL load the channel selected by cfg_ch on the next edge, except that a write to the currently granted channel while busy is ignored.
REQ-016 FSM states SHALL be IDLE, REQ, GRANT, XFER and RELEASE.
REQ-017 IDLE: if any armed channel has DREQ high, the sequencer SHALL latch the winner, go to REQ and assert HREQ the next cycle.
REQ-018 Arbitration SHALL be round-robin: when both channels request, grant the channel not last served; last served resets to IO2, so IO1 wins the first tie.
REQ-019 REQ: HREQ high; when HACK = 1, the sequencer SHALL go to GRANT.
REQ-020 GRANT: one cycle with DACKn = 1 and no bus strobes, then the sequencer SHALL go to XFER.
REQ-021 XFER: each cycle SHALL perform one word, driving AB = addr, Enable_memory = 1, Enable_IOn = 1, read_io = dir and read_memory = ~dir; on that edge addr increments modulo 256 and count decrements.
REQ-022 After each XFER cycle, the sequencer SHALL go to RELEASE with tc = 1 for one cycle if count reaches 0; otherwise it SHALL stay in XFER if DREQn = 1 and HACK = 1; otherwise it SHALL go to RELEASE with the remaining count preserved.
REQ-023 RELEASE: HREQ, DACKn and all strobes SHALL be 0; when HACK = 0, the sequencer SHALL go to IDLE and update the last-served channel.
REQ-024 If HACK drops in GRANT, the sequencer SHALL go to RELEASE with no transfer.
REQ-025 DREQ on an unarmed channel SHALL be ignored.
REQ-026 A cfg_we in the same cycle as a DREQ on that channel in IDLE SHALL apply the config first, with arbitration on the following cycle.
REQ-027 addr 8'hFF SHALL wrap to 8'h00 without error.
REQ-028 Outputs SHALL be registered and DACK1 and DACK2 SHALL never be high together.

Reset
REQ-029 rst SHALL immediately force IDLE and clear all channel registers.
REQ-030 rst SHALL immediately force 0 on HREQ, DACK1, DACK2, AB, Enable_memory, Enable_IO1, Enable_IO2, read_memory, read_io, word_count, tc and busy, and set last served to IO2.
REQ-031 Reset mid-transfer SHALL abort with no further strobes; the channel is then unarmed.

Structure
REQ-032 Shared package dma_pkg SHALL hold the state encoding, channel ID constants, the 8-bit address/count width parameter and the direction constants.
REQ-033 Per-channel registers SHALL be a sub-module dma_channel_regs, instantiated twice.

Verification
REQ-034 Bench SHALL cover: load IO1 addr = 150, count = 3, dir = 1; DREQ1 held; HACK returned 1 cycle after HREQ -> three XFER cycles with AB = 150, 151, 152 and read_io = 1, then tc pulse, HREQ low.
REQ-035 Bench SHALL cover: DREQ1 and DREQ2 both high, both armed -> first grant DACK1, second grant DACK2.
REQ-036 Bench SHALL cover: IO2 addr = 8'hFE, count = 4 -> AB = FE, FF, 00, 01.
REQ-037 Bench SHALL cover: count = 5 with DREQ1 dropped after 2 words -> RELEASE with word_count = 3; a re-raised DREQ1 resumes at addr + 2.
REQ-038 Bench SHALL cover: rst asserted during the second XFER -> all outputs 0 at once and a later DREQ1 is ignored.
